// File: rtl/fifo_multich.sv
// Multi-channel FIFO: NUM_CH independent circular buffers behind one shared write
// port, with per-channel registered read data, threshold flags, pause and sticky error.

module fifo_multich_ch #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE:0]   af_th,
  input  logic [ADDR_SIZE:0]   ae_th,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_pause,
  output logic                 fifo_error
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int CW    = ADDR_SIZE + 1;

  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} pause_st_e;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d, err_q, err_d;
  logic                 wr_acc, rd_acc, err_evt;
  pause_st_e            pst_q;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= af_th);
  assign almost_empty = (count_q <= ae_th) && !fifo_empty;

  // Acceptance is judged on the state at the edge: no pass-through, no fall-through.
  assign wr_acc  = wr_en && !fifo_full;
  assign rd_acc  = rd_en && !fifo_empty;
  assign err_evt = (wr_en && fifo_full) || (rd_en && fifo_empty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dv_d     = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set beats clear when both land in the same cycle.
    err_d = (err_q && !err_clr) || err_evt;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  // Hysteretic pause; the enter condition wins when thresholds overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pst_q <= RUN;
    else begin
      case (pst_q)
        RUN:     if (count_q >= af_th) pst_q <= PAUSE;
        PAUSE:   if (count_q < af_th && count_q <= ae_th) pst_q <= RUN;
        default: pst_q <= RUN;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign fifo_error = err_q;
  assign fifo_pause = (pst_q == PAUSE);
endmodule

module fifo_multich #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write,
  input  logic [CH_W-1:0]             wr_ch,
  input  logic [DATA_SIZE-1:0]        data_in,
  input  logic [NUM_CH-1:0]           read,
  input  logic [ADDR_SIZE:0]          af_th,
  input  logic [ADDR_SIZE:0]          ae_th,
  input  logic [NUM_CH-1:0]           err_clr,
  output logic [NUM_CH*DATA_SIZE-1:0] data_out,
  output logic [NUM_CH-1:0]           data_valid,
  output logic [NUM_CH-1:0]           fifo_empty,
  output logic [NUM_CH-1:0]           fifo_full,
  output logic [NUM_CH-1:0]           almost_full,
  output logic [NUM_CH-1:0]           almost_empty,
  output logic [NUM_CH-1:0]           fifo_pause,
  output logic [NUM_CH-1:0]           fifo_error
);
  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range wr_ch matches no channel, so such writes vanish without side effects.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_sel[c] = write && (wr_ch == CH_W'(c));

    fifo_multich_ch #(
      .DATA_SIZE(DATA_SIZE),
      .ADDR_SIZE(ADDR_SIZE)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_sel[c]),
      .data_in     (data_in),
      .rd_en       (read[c]),
      .af_th       (af_th),
      .ae_th       (ae_th),
      .err_clr     (err_clr[c]),
      .data_out    (data_out[c*DATA_SIZE +: DATA_SIZE]),
      .data_valid  (data_valid[c]),
      .fifo_empty  (fifo_empty[c]),
      .fifo_full   (fifo_full[c]),
      .almost_full (almost_full[c]),
      .almost_empty(almost_empty[c]),
      .fifo_pause  (fifo_pause[c]),
      .fifo_error  (fifo_error[c])
    );
  end
endmodule

// File: tb/tb_fifo_multich.sv
// Directed bench for fifo_multich: vector table for single-cycle behaviour, then
// hand-written sequences for reset, pause hysteresis and pointer wrap.

module tb_fifo_multich;
  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [1:0]  wr_ch;
  logic [5:0]  data_in;
  logic [3:0]  read, err_clr;
  logic [2:0]  af_th, ae_th;
  logic [23:0] data_out;
  logic [3:0]  data_valid, fifo_empty, fifo_full, almost_full, almost_empty;
  logic [3:0]  fifo_pause, fifo_error;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_multich #(.DATA_SIZE(6), .ADDR_SIZE(2), .NUM_CH(4), .CH_W(2)) dut (
    .clk(clk), .reset(reset), .write(write), .wr_ch(wr_ch), .data_in(data_in),
    .read(read), .af_th(af_th), .ae_th(ae_th), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_pause(fifo_pause), .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       wr;
    logic [1:0] ch;
    logic [5:0] din;
    logic [3:0] rd, clr;
    logic [3:0] dv, emp, full, err, pse, af, ae;
    int         dch;
    logic [5:0] dout;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [5:0] dout_ch(input int c);
    logic [23:0] d;
    d = data_out;
    return d[c*6 +: 6];
  endfunction

  task automatic drive(input logic wr, input logic [1:0] ch, input logic [5:0] din,
                       input logic [3:0] rd, input logic [3:0] clr);
    write = wr; wr_ch = ch; data_in = din; read = rd; err_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 6'h00, 4'h0, 4'h0);
  endtask

  initial begin
    // {wr, ch, din, rd, clr, | dv, emp, full, err, pse, af, ae, dch, dout}
    vt[0]  = '{1'b1, 2'd2, 6'h11, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 2, 6'h00};
    vt[1]  = '{1'b1, 2'd2, 6'h22, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 6'h00};
    vt[2]  = '{1'b1, 2'd2, 6'h33, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 2, 6'h00};
    vt[3]  = '{1'b1, 2'd2, 6'h04, 4'h0, 4'h0, 4'h0, 4'hB, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 2, 6'h00};
    vt[4]  = '{1'b0, 2'd0, 6'h00, 4'h4, 4'h0, 4'h4, 4'hB, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 2, 6'h11};
    vt[5]  = '{1'b0, 2'd0, 6'h00, 4'h4, 4'h0, 4'h4, 4'hB, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 2, 6'h22};
    vt[6]  = '{1'b0, 2'd0, 6'h00, 4'h4, 4'h0, 4'h4, 4'hB, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 2, 6'h33};
    vt[7]  = '{1'b0, 2'd0, 6'h00, 4'h4, 4'h0, 4'h4, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 6'h04};
    vt[8]  = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 6'h04};
    vt[9]  = '{1'b1, 2'd1, 6'h01, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 2, 6'h04};
    vt[10] = '{1'b1, 2'd1, 6'h02, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 6'h04};
    vt[11] = '{1'b1, 2'd1, 6'h03, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 2, 6'h04};
    vt[12] = '{1'b1, 2'd1, 6'h05, 4'h0, 4'h0, 4'h0, 4'hD, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 2, 6'h04};
    vt[13] = '{1'b1, 2'd1, 6'h3F, 4'h2, 4'h0, 4'h2, 4'hD, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 1, 6'h01};
    vt[14] = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 1, 6'h01};
    vt[15] = '{1'b0, 2'd0, 6'h00, 4'h2, 4'h0, 4'h2, 4'hD, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 1, 6'h02};
    vt[16] = '{1'b0, 2'd0, 6'h00, 4'h2, 4'h0, 4'h2, 4'hD, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 1, 6'h03};
    vt[17] = '{1'b0, 2'd0, 6'h00, 4'h2, 4'h0, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 6'h05};
    vt[18] = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 6'h05};
    vt[19] = '{1'b0, 2'd0, 6'h00, 4'h8, 4'h0, 4'h0, 4'hF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 3, 6'h00};
    vt[20] = '{1'b0, 2'd0, 6'h00, 4'h8, 4'h8, 4'h0, 4'hF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 3, 6'h00};
    vt[21] = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h8, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3, 6'h00};

    af_th = 3'd3; ae_th = 3'd1;
    drive(1'b0, 2'd0, 6'h00, 4'h0, 4'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_empty", -1, {4'h0, fifo_empty}, 8'h0F);
    chk("rst_full",  -1, {4'h0, fifo_full},  8'h00);
    chk("rst_af_ae", -1, {almost_full, almost_empty}, 8'h00);
    chk("rst_pause_err", -1, {fifo_pause, fifo_error}, 8'h00);
    chk("rst_dv",    -1, {4'h0, data_valid}, 8'h00);

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].wr, vt[i].ch, vt[i].din, vt[i].rd, vt[i].clr);
      step();
      chk("dv",    i, {4'h0, data_valid},   {4'h0, vt[i].dv});
      chk("empty", i, {4'h0, fifo_empty},   {4'h0, vt[i].emp});
      chk("full",  i, {4'h0, fifo_full},    {4'h0, vt[i].full});
      chk("error", i, {4'h0, fifo_error},   {4'h0, vt[i].err});
      chk("pause", i, {4'h0, fifo_pause},   {4'h0, vt[i].pse});
      chk("afull", i, {4'h0, almost_full},  {4'h0, vt[i].af});
      chk("aempty",i, {4'h0, almost_empty}, {4'h0, vt[i].ae});
      chk("dout",  i, {2'b00, dout_ch(vt[i].dch)}, {2'b00, vt[i].dout});
    end

    // Reset mid-stream: ch0 holds two words, ch3 has an error, a ch0 read is pending.
    drive(1'b1, 2'd0, 6'h0A, 4'h0, 4'h0); step();
    drive(1'b1, 2'd0, 6'h0B, 4'h0, 4'h0); step();
    drive(1'b0, 2'd0, 6'h00, 4'h8, 4'h0); step();
    chk("pre_rst_state", 100, {fifo_error, fifo_empty}, 8'h8E);
    drive(1'b0, 2'd0, 6'h00, 4'h1, 4'h0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_empty", 101, {4'h0, fifo_empty}, 8'h0F);
    chk("midrst_pause_err", 101, {fifo_pause, fifo_error}, 8'h00);
    chk("midrst_dv", 101, {4'h0, data_valid}, 8'h00);
    @(posedge clk); #1;
    chk("midrst_no_dv", 102, {4'h0, data_valid}, 8'h00);
    chk("midrst_dout0", 102, {2'b00, dout_ch(0)}, 8'h00);
    read = 4'h0;
    reset = 1'b0;

    // Pause hysteresis on ch0.
    drive(1'b1, 2'd0, 6'h0A, 4'h0, 4'h0); step();
    drive(1'b1, 2'd0, 6'h0B, 4'h0, 4'h0); step();
    drive(1'b1, 2'd0, 6'h0C, 4'h0, 4'h0); step();
    step();
    chk("pause_set", 200, {4'h0, fifo_pause}, 8'h01);
    drive(1'b0, 2'd0, 6'h00, 4'h1, 4'h0); step();
    chk("p_rd1_dout", 201, {data_valid, 2'b00, dout_ch(0)[1:0]}, {4'h1, 4'h2});
    chk("p_rd1_val", 201, {2'b00, dout_ch(0)}, 8'h0A);
    step();
    chk("pause_hold_cnt2", 202, {4'h0, fifo_pause}, 8'h01);
    drive(1'b0, 2'd0, 6'h00, 4'h1, 4'h0); step();
    chk("p_rd2_val", 203, {2'b00, dout_ch(0)}, 8'h0B);
    step();
    chk("pause_release", 204, {4'h0, fifo_pause}, 8'h00);

    // Simultaneous read/write at count 2, then drain across the pointer wrap.
    drive(1'b1, 2'd0, 6'h0D, 4'h0, 4'h0); step();
    drive(1'b1, 2'd0, 6'h2A, 4'h1, 4'h0); step();
    chk("rw_dout", 300, {2'b00, dout_ch(0)}, 8'h0C);
    chk("rw_dv", 300, {4'h0, data_valid}, 8'h01);
    chk("rw_count2_flags", 300,
        {fifo_empty[0], fifo_full[0], almost_full[0], almost_empty[0], fifo_error}, 8'h00);
    drive(1'b0, 2'd0, 6'h00, 4'h1, 4'h0); step();
    chk("wrap_rd_d", 301, {2'b00, dout_ch(0)}, 8'h0D);
    chk("wrap_ae", 301, {4'h0, almost_empty}, 8'h01);
    drive(1'b0, 2'd0, 6'h00, 4'h1, 4'h0); step();
    chk("wrap_rd_2a", 302, {2'b00, dout_ch(0)}, 8'h2A);
    chk("wrap_empty", 302, {4'h0, fifo_empty}, 8'h0F);
    drive(1'b0, 2'd0, 6'h00, 4'h1, 4'h0); step();
    chk("underflow_err", 303, {data_valid, fifo_error}, 8'h01);
    chk("underflow_hold", 303, {2'b00, dout_ch(0)}, 8'h2A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
